// File: rtl/serial_bitwise_logic_unit.sv
// Bit-serial NOT/AND/OR/XOR engine: one operand bit per clock, LSB first, valid/ready on both sides.
// Optional serial parity of the result is enabled by defining SERIAL_BITWISE_PARITY_EN.
module serial_bitwise_logic_unit #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         busy
`ifdef SERIAL_BITWISE_PARITY_EN
   ,
   output logic         parity
`endif
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic [N-1:0]  res;
   logic [1:0]    op_r;
   logic [CW-1:0] cnt;
   logic          gate_c;
   logic          accept_c;
   logic          last_c;
   logic [N-1:0]  res_nx_c;

   // Single shared gate evaluated on the current LSB of the operand shift registers.
   always_comb begin
      gate_c = 1'b0;
      case (op_r)
         2'b00:   gate_c = ~a_sh[0];
         2'b01:   gate_c = a_sh[0] & b_sh[0];
         2'b10:   gate_c = a_sh[0] | b_sh[0];
         default: gate_c = a_sh[0] ^ b_sh[0];
      endcase
   end

   assign accept_c = (state == IDLE) && in_valid;
   assign last_c   = (cnt == CW'(N - 1));
   assign res_nx_c = (res >> 1) | (N'(gate_c) << (N - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept_c)  state_nx = SHIFT;
         SHIFT:   if (last_c)    state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register; handshake/status outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         in_ready  <= (state_nx == IDLE);
         out_valid <= (state_nx == DONE);
         busy      <= (state_nx != IDLE);
      end
   end

   // Datapath: c is only written on the final shift so it is stable outside DONE entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         res  <= '0;
         op_r <= 2'b00;
         cnt  <= '0;
         c    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  a_sh <= a;
                  b_sh <= b;
                  op_r <= op;
                  res  <= '0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               res  <= res_nx_c;
               cnt  <= cnt + CW'(1);
               if (last_c) c <= res_nx_c;
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_BITWISE_PARITY_EN
   logic par_acc;

   // Parity folds in each gate output and is published together with c.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_acc <= 1'b0;
         parity  <= 1'b0;
      end else begin
         if (accept_c) begin
            par_acc <= 1'b0;
         end else if (state == SHIFT) begin
            par_acc <= par_acc ^ gate_c;
            if (last_c) parity <= par_acc ^ gate_c;
         end
      end
   end
`endif

endmodule

// File: tb/tb_serial_bitwise_logic_unit.sv
// Randomized and directed bench for serial_bitwise_logic_unit against a whole-word bitwise model.
module tb_serial_bitwise_logic_unit;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [1:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] c;
   logic         busy;
`ifdef SERIAL_BITWISE_PARITY_EN
   logic         parity;
`endif

   int checks = 0;
   int errors = 0;

   serial_bitwise_logic_unit #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .busy      (busy)
`ifdef SERIAL_BITWISE_PARITY_EN
      ,
      .parity    (parity)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
      case (o)
         2'b00:   return ~x;
         2'b01:   return x & y;
         2'b10:   return x | y;
         default: return x ^ y;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full request: accept, measure latency, check result, optional backpressure, handshake.
   task automatic do_req(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input int hold, input string name);
      logic [N-1:0] exp;
      int lat;
      int w;
      exp = model(o, x, y);
      in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
      w = 0;
      while (!in_ready && w < 4 * N) begin tick(); w++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL %s accept: in_ready=%0b required 1", name, in_ready);
      end
      tick();
      in_valid = 1'b0; a = N'($urandom); b = N'($urandom); op = 2'($urandom);
      lat = 0;
      while (!out_valid && lat < 4 * N) begin tick(); lat++; end
      checks++;
      if (lat !== N) begin
         errors++; $display("FAIL %s latency: got %0d edges required %0d", name, lat, N);
      end
      checks++;
      if (c !== exp) begin
         errors++; $display("FAIL %s result: c=%h required %h", name, c, exp);
      end
`ifdef SERIAL_BITWISE_PARITY_EN
      checks++;
      if (parity !== ^exp) begin
         errors++; $display("FAIL %s parity: got %0b required %0b", name, parity, ^exp);
      end
`endif
      for (int i = 0; i < hold; i++) begin
         tick();
         checks++;
         if ({out_valid, c} !== {1'b1, exp}) begin
            errors++; $display("FAIL %s hold%0d: out_valid=%0b c=%h required 1 %h", name, i, out_valid, c, exp);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++; $display("FAIL %s release: out_valid=%0b in_ready=%0b required 0 1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 2'b00;
      tick(); tick();
      checks++;
      if ({in_ready, out_valid, busy, c} !== {1'b1, 1'b0, 1'b0, N'(0)}) begin
         errors++; $display("FAIL reset: in_ready=%0b out_valid=%0b busy=%0b c=%h required 1 0 0 0",
                            in_ready, out_valid, busy, c);
      end
`ifdef SERIAL_BITWISE_PARITY_EN
      checks++;
      if (parity !== 1'b0) begin
         errors++; $display("FAIL reset parity: got %0b required 0", parity);
      end
`endif
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      do_req(2'b00, 8'hA5, 8'h00, 0, "not_a5");
      do_req(2'b11, 8'hFF, 8'h0F, 0, "xor_ff_0f");
      do_req(2'b01, 8'hCC, 8'hAA, 0, "and_cc_aa");
      do_req(2'b10, 8'h81, 8'h18, 0, "or_81_18");
   endtask

   task automatic test_hold();
      do_req(2'b11, 8'h3C, 8'h55, 5, "hold5");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         do_req(2'($urandom), N'($urandom), N'($urandom), int'($urandom_range(0, 2)), "random");
   endtask

   task automatic test_ignore();
      int w;
      in_valid = 1'b1; op = 2'b00; a = 8'h3C; b = 8'h00; out_ready = 1'b0;
      tick();
      op = 2'b11; a = 8'hFF; b = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({in_ready, busy} !== 2'b01) begin
            errors++; $display("FAIL ignore busy%0d: in_ready=%0b busy=%0b required 0 1", i, in_ready, busy);
         end
      end
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 4 * N) begin tick(); w++; end
      checks++;
      if ({out_valid, c} !== {1'b1, 8'hC3}) begin
         errors++; $display("FAIL ignore result: out_valid=%0b c=%h required 1 c3", out_valid, c);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; op = 2'b01; a = 8'hF0; b = 8'hFF; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({in_ready, out_valid, busy, c} !== {1'b1, 1'b0, 1'b0, N'(0)}) begin
         errors++; $display("FAIL mid_reset: in_ready=%0b out_valid=%0b busy=%0b c=%h required 1 0 0 0",
                            in_ready, out_valid, busy, c);
      end
      do_req(2'b10, 8'h12, 8'h40, 1, "after_reset");
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] q[$];
      logic [N-1:0] exp;
      int cyc;
      int last_acc;
      int got;
      logic acc;
      logic xfer;
      cyc = 0; last_acc = -1; got = 0;
      out_ready = 1'b1; in_valid = 1'b1;
      op = 2'($urandom); a = N'($urandom); b = N'($urandom);
      while (got < 6 && cyc < 20 * (N + 2)) begin
         acc  = in_ready;
         xfer = out_valid;
         if (acc) q.push_back(model(op, a, b));
         if (xfer) begin
            got++;
            exp = (q.size() > 0) ? q.pop_front() : ~c;
            checks++;
            if (c !== exp) begin
               errors++; $display("FAIL b2b result%0d: c=%h required %h", got, c, exp);
            end
         end
         tick();
         cyc++;
         if (acc) begin
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc !== int'(N + 2)) begin
                  errors++; $display("FAIL b2b period: got %0d cycles required %0d", cyc - last_acc, N + 2);
               end
            end
            last_acc = cyc;
            op = 2'($urandom); a = N'($urandom); b = N'($urandom);
         end
      end
      checks++;
      if (got !== 6) begin
         errors++; $display("FAIL b2b timeout: got %0d results required 6", got);
      end
      in_valid = 1'b0;
      repeat (N + 3) tick();
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_ignore();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
